// File: rtl/host_spi_pkg.sv
// Shared types and constants for the host SPI target front-end.
package host_spi_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic       MISO_IDLE = 1'b1;
   localparam logic [7:0] TX_FILL   = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses on the synced level.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] chain;
   logic [STAGES-1:0] fill;
   logic              prev;
   logic              primed;

   // Edges are suppressed until the chain holds real pin samples, so a pin already
   // low when reset is released does not look like a falling edge.
   assign primed = fill[STAGES-1];

   // Synchroniser chain, fill tracker and previous-level register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         fill  <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         fill  <= {fill[STAGES-2:0], 1'b1};
         prev  <= primed ? chain[STAGES-1] : 1'b0;
      end
   end

   assign q      = chain[STAGES-1];
   assign rise_c = primed &  q & ~prev;
   assign fall_c = primed & ~q &  prev;

endmodule

// File: rtl/host_spi_frontend.sv
// Oversampled SPI mode-0 target: framed byte receive and handshaked byte transmit.
module host_spi_frontend
   import host_spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned IDX_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             h_clk,
   input  logic             h_cs_n,
   input  logic             h_mosi,
   output logic             h_miso,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             rx_first,
   output logic [IDX_W-1:0] byte_idx,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             cs_start,
   output logic             cs_end,
   output logic             active,
   output logic             tx_underrun
);

   logic cs_sync, cs_rise_c, cs_fall_c;
   logic sck_sync, sck_rise_c, sck_fall_c;
   logic mosi_sync, mosi_rise_c, mosi_fall_c;
   logic unused_c;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .d(h_cs_n), .q(cs_sync), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst(rst), .d(h_clk), .q(sck_sync), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .rst(rst), .d(h_mosi), .q(mosi_sync), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
   );

   // Levels of the edge channels and edges of the data channel are not needed.
   assign unused_c = ^{cs_sync, sck_sync, mosi_rise_c, mosi_fall_c};

   state_t           state, state_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [6:0]       rx_shift, rx_shift_n;
   logic [7:0]       tx_shift, tx_shift_n;
   logic [7:0]       tx_buf, tx_buf_n;
   logic [IDX_W-1:0] idx_cnt, idx_cnt_n, byte_idx_n;
   logic [7:0]       rx_data_n;
   logic             rx_valid_n, rx_first_n, tx_ready_n, cs_start_n, cs_end_n;
   logic             active_n, tx_underrun_n, h_miso_n;
   logic             load_c, flush_c, accept_c;

   assign accept_c = tx_valid && tx_ready;

   // Next-state, framing, shift registers and tx buffer handling.
   always_comb begin
      state_n       = state;
      bit_cnt_n     = bit_cnt;
      rx_shift_n    = rx_shift;
      tx_shift_n    = tx_shift;
      tx_buf_n      = tx_buf;
      idx_cnt_n     = idx_cnt;
      byte_idx_n    = byte_idx;
      rx_data_n     = rx_data;
      rx_valid_n    = 1'b0;
      rx_first_n    = 1'b0;
      tx_ready_n    = tx_ready;
      cs_start_n    = 1'b0;
      cs_end_n      = 1'b0;
      active_n      = active;
      tx_underrun_n = 1'b0;
      load_c        = 1'b0;
      flush_c       = 1'b0;

      case (state)
         IDLE: begin
            if (cs_fall_c) begin
               state_n    = SHIFT;
               cs_start_n = 1'b1;
               active_n   = 1'b1;
               bit_cnt_n  = 3'd0;
               idx_cnt_n  = '0;
               byte_idx_n = '0;
               load_c     = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_rise_c) begin
               state_n  = IDLE;
               cs_end_n = 1'b1;
               active_n = 1'b0;
               flush_c  = 1'b1;
            end else if (sck_rise_c) begin
               rx_shift_n = {rx_shift[5:0], mosi_sync};
               bit_cnt_n  = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_data_n  = {rx_shift, mosi_sync};
                  rx_valid_n = 1'b1;
                  rx_first_n = (idx_cnt == '0);
                  byte_idx_n = idx_cnt;
                  if (idx_cnt != '1) begin
                     idx_cnt_n = idx_cnt + IDX_W'(1);
                  end
                  bit_cnt_n = 3'd0;
                  load_c    = 1'b1;
               end
            end else if (sck_fall_c && (bit_cnt != 3'd0)) begin
               tx_shift_n = {tx_shift[6:0], 1'b1};
            end
         end
         default: state_n = IDLE;
      endcase

      // A load always takes the buffer content as it stood before this cycle's accept.
      if (load_c) begin
         if (tx_ready) begin
            tx_shift_n    = TX_FILL;
            tx_underrun_n = 1'b1;
         end else begin
            tx_shift_n = tx_buf;
         end
         tx_ready_n = 1'b1;
      end
      if (flush_c) begin
         tx_ready_n = 1'b1;
      end
      if (accept_c) begin
         tx_buf_n   = tx_data;
         tx_ready_n = 1'b0;
      end

      h_miso_n = (state_n == SHIFT) ? tx_shift_n[7] : MISO_IDLE;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= 3'd0;
         rx_shift    <= 7'd0;
         tx_shift    <= TX_FILL;
         tx_buf      <= 8'd0;
         idx_cnt     <= '0;
         byte_idx    <= '0;
         rx_data     <= 8'd0;
         rx_valid    <= 1'b0;
         rx_first    <= 1'b0;
         tx_ready    <= 1'b1;
         cs_start    <= 1'b0;
         cs_end      <= 1'b0;
         active      <= 1'b0;
         tx_underrun <= 1'b0;
         h_miso      <= MISO_IDLE;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         rx_shift    <= rx_shift_n;
         tx_shift    <= tx_shift_n;
         tx_buf      <= tx_buf_n;
         idx_cnt     <= idx_cnt_n;
         byte_idx    <= byte_idx_n;
         rx_data     <= rx_data_n;
         rx_valid    <= rx_valid_n;
         rx_first    <= rx_first_n;
         tx_ready    <= tx_ready_n;
         cs_start    <= cs_start_n;
         cs_end      <= cs_end_n;
         active      <= active_n;
         tx_underrun <= tx_underrun_n;
         h_miso      <= h_miso_n;
      end
   end

endmodule

// File: tb/tb_host_spi_frontend.sv
// Scoreboard bench for host_spi_frontend: host SPI model, rx/tx expectation queues.
module tb_host_spi_frontend;

   localparam int         HALF = 8;
   localparam logic [7:0] FILL = 8'hFF;
   localparam logic [31:0] RST_OUTS = {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   typedef struct packed {
      logic [7:0]  data;
      logic        is_first;
      logic [15:0] idx;
   } rx_exp_t;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        h_clk    = 1'b0;
   logic        h_cs_n   = 1'b1;
   logic        h_mosi   = 1'b0;
   logic [7:0]  tx_data  = 8'h00;
   logic        tx_valid = 1'b0;

   logic        h_miso, rx_valid, rx_first, tx_ready, cs_start, cs_end, active, tx_underrun;
   logic [7:0]  rx_data;
   logic [15:0] byte_idx;

   logic        h_miso2, rx_valid2, rx_first2, tx_ready2, cs_start2, cs_end2, active2, tx_underrun2;
   logic [7:0]  rx_data2;
   logic [1:0]  byte_idx2;
   logic        unused_twin;

   logic [31:0] outs;

   int vectors     = 0;
   int miscompares = 0;
   int n_start = 0, n_end = 0, n_urun = 0, n_urun_start = 0;

   rx_exp_t    rx_q[$];
   logic [7:0] tx_q[$];
   rx_exp_t    mon_e;
   logic [1:0] mon_idx2;

   always #5 clk = ~clk;

   host_spi_frontend #(.SYNC_STAGES(2), .IDX_W(16)) dut (
      .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi), .h_miso(h_miso),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .byte_idx(byte_idx),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cs_start(cs_start),
      .cs_end(cs_end), .active(active), .tx_underrun(tx_underrun)
   );

   host_spi_frontend #(.SYNC_STAGES(2), .IDX_W(2)) dut2 (
      .clk(clk), .rst(rst), .h_clk(h_clk), .h_cs_n(h_cs_n), .h_mosi(h_mosi), .h_miso(h_miso2),
      .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_first(rx_first2), .byte_idx(byte_idx2),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready2), .cs_start(cs_start2),
      .cs_end(cs_end2), .active(active2), .tx_underrun(tx_underrun2)
   );

   assign unused_twin = ^{h_miso2, rx_first2, tx_ready2, cs_start2, cs_end2, active2, tx_underrun2};
   assign outs = {h_miso, rx_data, rx_valid, rx_first, byte_idx, tx_ready, cs_start, cs_end, active, tx_underrun};

   // Output monitor: rx scoreboard and pulse counters, sampled on the falling edge.
   always @(negedge clk) begin
      if (rx_valid || rx_valid2) begin
         vectors++;
         if (rx_q.size() == 0) begin
            miscompares++;
            $display("FAIL rx_unexpected: got rx_valid=%b rx_valid2=%b data=%h, want no rx_valid", rx_valid, rx_valid2, rx_data);
         end else begin
            mon_e    = rx_q.pop_front();
            mon_idx2 = (mon_e.idx > 16'd3) ? 2'd3 : mon_e.idx[1:0];
            if ({rx_valid, rx_valid2, rx_data, rx_first, byte_idx, rx_data2, byte_idx2} !==
                {2'b11, mon_e.data, mon_e.is_first, mon_e.idx, mon_e.data, mon_idx2}) begin
               miscompares++;
               $display("FAIL rx_byte: got v=%b%b data=%h first=%b idx=%0d data2=%h idx2=%0d, want data=%h first=%b idx=%0d idx2=%0d",
                        rx_valid, rx_valid2, rx_data, rx_first, byte_idx, rx_data2, byte_idx2,
                        mon_e.data, mon_e.is_first, mon_e.idx, mon_idx2);
            end
         end
      end
      if (cs_start) n_start++;
      if (cs_end) n_end++;
      if (tx_underrun) n_urun++;
      if (tx_underrun && cs_start) n_urun_start++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Host shifts nbits of mosi_b MSB first, sampling MISO just before each rise.
   task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
      miso_b = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         h_mosi = mosi_b[i];
         wait_clks(HALF);
         miso_b[i] = h_miso;
         h_clk = 1'b1;
         wait_clks(HALF);
         h_clk = 1'b0;
      end
   endtask

   // Full-byte transaction; expected rx bytes and MISO bytes come from the queues.
   task automatic spi_xfer(input int nbytes, input logic [7:0] seed);
      logic [7:0] d, got, exp_miso;
      rx_exp_t    ex;
      h_cs_n = 1'b0;
      wait_clks(HALF);
      for (int b = 0; b < nbytes; b++) begin
         d           = seed ^ 8'(b * 37);
         ex.data     = d;
         ex.is_first = (b == 0);
         ex.idx      = 16'(b);
         rx_q.push_back(ex);
         spi_bits(d, 8, got);
         exp_miso = (tx_q.size() != 0) ? tx_q.pop_front() : FILL;
         vectors++;
         if (got !== exp_miso) begin
            miscompares++;
            $display("FAIL miso_byte%0d: got %h want %h", b, got, exp_miso);
         end
      end
      wait_clks(HALF);
      h_cs_n = 1'b1;
      wait_clks(2 * HALF);
      tx_q.delete();
   endtask

   task automatic tx_send(input logic [7:0] d);
      int guard;
      guard = 0;
      while (tx_ready !== 1'b1 && guard < 400) begin
         wait_clks(1);
         guard++;
      end
      vectors++;
      if (tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL tx_ready_timeout: tx_ready=%b after %0d cycles, want 1", tx_ready, guard);
      end else begin
         tx_data  = d;
         tx_valid = 1'b1;
         wait_clks(1);
         tx_valid = 1'b0;
         tx_q.push_back(d);
      end
   endtask

   task automatic check_rx_drained(input string name);
      vectors++;
      if (rx_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_rx_missing: %0d bytes outstanding, want 0", name, rx_q.size());
         rx_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clks(4);
      vectors++;
      if (outs !== RST_OUTS) begin
         miscompares++;
         $display("FAIL reset_hold: got %h want %h", outs, RST_OUTS);
      end
      rst = 1'b0;
      wait_clks(HALF);
      vectors++;
      if (outs !== RST_OUTS) begin
         miscompares++;
         $display("FAIL reset_release: got %h want %h", outs, RST_OUTS);
      end
   endtask

   task automatic test_single_byte();
      int e0;
      e0 = n_end;
      spi_xfer(1, 8'h9F);
      check_rx_drained("single");
      vectors++;
      if ({n_end - e0, 31'(active)} !== {32'd1, 31'd0}) begin
         miscompares++;
         $display("FAIL single_end: got cs_end count %0d active %b, want 1 and 0", n_end - e0, active);
      end
   endtask

   task automatic test_tx_stream();
      int u0;
      tx_send(8'hA5);
      u0 = n_urun;
      fork
         spi_xfer(2, 8'h12);
         begin
            tx_send(8'h3C);
            tx_send(8'h00);
         end
      join
      check_rx_drained("stream");
      vectors++;
      if (n_urun - u0 !== 0) begin
         miscompares++;
         $display("FAIL stream_underrun: got %0d pulses want 0", n_urun - u0);
      end
   endtask

   task automatic test_underrun();
      int u0, us0;
      u0  = n_urun;
      us0 = n_urun_start;
      spi_xfer(1, 8'h00);
      check_rx_drained("underrun");
      vectors++;
      if (n_urun_start - us0 !== 1) begin
         miscompares++;
         $display("FAIL underrun_at_start: got %0d want 1", n_urun_start - us0);
      end
      // One pulse at the start load, one at the reload after the only byte.
      vectors++;
      if (n_urun - u0 !== 2) begin
         miscompares++;
         $display("FAIL underrun_total: got %0d want 2", n_urun - u0);
      end
   endtask

   task automatic test_partial();
      int e0;
      logic [7:0] got;
      tx_send(8'h11);
      e0 = n_end;
      fork
         begin
            h_cs_n = 1'b0;
            wait_clks(HALF);
            spi_bits(8'hF0, 5, got);
            wait_clks(HALF);
            h_cs_n = 1'b1;
            wait_clks(2 * HALF);
         end
         tx_send(8'h22);
      join
      tx_q.delete();
      check_rx_drained("partial");
      vectors++;
      if (got[7:3] !== 5'b00010) begin
         miscompares++;
         $display("FAIL partial_miso: got %b want 00010", got[7:3]);
      end
      vectors++;
      if ({n_end - e0, 31'({h_miso, tx_ready, active})} !== {32'd1, 31'b110}) begin
         miscompares++;
         $display("FAIL partial_end: got cs_end count %0d miso %b tx_ready %b active %b, want 1 1 1 0",
                  n_end - e0, h_miso, tx_ready, active);
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      logic [7:0] got;
      h_cs_n = 1'b0;
      wait_clks(HALF);
      spi_bits(8'hAA, 3, got);
      h_clk = 1'b1;
      wait_clks(2);
      rst = 1'b1;
      wait_clks(2);
      vectors++;
      if (outs !== RST_OUTS) begin
         miscompares++;
         $display("FAIL midrst_hold: got %h want %h", outs, RST_OUTS);
      end
      h_clk = 1'b0;
      rst   = 1'b0;
      s0    = n_start;
      wait_clks(4 * HALF);
      vectors++;
      if ({n_start - s0, outs} !== {32'd0, RST_OUTS}) begin
         miscompares++;
         $display("FAIL midrst_release: got starts %0d outs %h, want 0 and %h", n_start - s0, outs, RST_OUTS);
      end
      h_cs_n = 1'b1;
      wait_clks(2 * HALF);
      h_cs_n = 1'b0;
      wait_clks(2 * HALF);
      vectors++;
      if ({n_start - s0, 31'(active)} !== {32'd1, 31'd1}) begin
         miscompares++;
         $display("FAIL midrst_restart: got starts %0d active %b, want 1 and 1", n_start - s0, active);
      end
      h_cs_n = 1'b1;
      wait_clks(2 * HALF);
      tx_q.delete();
   endtask

   task automatic test_idx_saturate();
      spi_xfer(6, 8'h30);
      check_rx_drained("idx");
   endtask

   task automatic test_back_to_back();
      int s0, e0;
      s0 = n_start;
      e0 = n_end;
      spi_xfer(1, 8'h5A);
      spi_xfer(1, 8'hC3);
      check_rx_drained("b2b");
      vectors++;
      if ({n_start - s0, n_end - e0} !== {32'd2, 32'd2}) begin
         miscompares++;
         $display("FAIL b2b_framing: got starts %0d ends %0d, want 2 and 2", n_start - s0, n_end - e0);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_tx_stream();
      test_underrun();
      test_partial();
      test_reset_mid();
      test_idx_saturate();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/host_spi_frontend.md
# host_spi_frontend

Oversampled SPI mode-0 target front-end sitting directly downstream of the host mux: it consumes the selected host's h_clk/h_cs_n/h_mosi and drives h_miso back. All host signals are synchronised into the system clock domain. The block then delivers received bytes with transaction framing (start, end, first byte, byte index) to the command decoder, and serialises response bytes taken over a valid/ready handshake.

## Interface
- SYNC_STAGES, 2, synchroniser depth on h_clk/h_cs_n/h_mosi (≥2)
- IDX_W, 16, width of byte_idx
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- h_clk  in  1  selected host SPI clock (mode 0, idle low)
- h_cs_n  in  1  selected host chip select, active low
- h_mosi  in  1  selected host data in
- h_miso  out  1  data to selected host; 1 when idle
- rx_data  out  8  last received byte, MSB first on wire
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_first  out  1  qualifies rx_valid: byte is opcode (index 0)
- byte_idx  out  IDX_W  index of byte on rx_data, saturating
- tx_data  in  8  next response byte
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  one-entry tx buffer empty
- cs_start  out  1  one-cycle pulse on transaction start
- cs_end  out  1  one-cycle pulse on transaction end
- active  out  1  high between cs_start and cs_end
- tx_underrun  out  1  one-cycle pulse: byte load found empty buffer

## Operation
- Synchronisers: SYNC_STAGES flops each; h_cs_n chain resets to 1, h_clk and h_mosi chains to 0. Edge detect on synced h_clk/h_cs_n via one prev register. prev_cs resets to 0, so CS held low through reset produces no start; a new transaction needs CS seen high then low.
- States: IDLE, SHIFT.
- IDLE: h_miso=1. Synced CS fall → cs_start, active=1, bit_cnt=0, byte_idx=0. Load tx_shift from buffer, or 8'hFF plus tx_underrun if empty. Go to SHIFT. SCLK edges ignored.
- SHIFT, SCLK rise: rx_shift ← {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - When bit_cnt was 7: rx_data ← assembled byte, rx_valid=1, rx_first=(byte_idx==0).
  - byte_idx increments after that byte, saturating at all-ones.
  - bit_cnt ← 0; tx_shift reloads from buffer (or 8'hFF + tx_underrun).
- SHIFT, SCLK fall with bit_cnt≠0: tx_shift ← {tx_shift[6:0],1}. A fall with bit_cnt==0 does not shift.
- h_miso = tx_shift[7] in SHIFT.
- Synced CS rise (any state SHIFT) → cs_end, active=0, IDLE. Partial byte discarded (no rx_valid); tx buffer flushed (tx_ready=1); h_miso=1.
- CS rise and SCLK rise in same cycle: CS wins, edge ignored.
- tx handshake: transfer when tx_valid&&tx_ready. Accepted in either state. tx_ready drops the cycle after acceptance and rises the cycle after the buffer is loaded into tx_shift. Acceptance and load in the same cycle: the load takes the old content, the new byte stays in the buffer.
- Reset outputs: h_miso=1, rx_data=0, rx_valid=0, rx_first=0, byte_idx=0, tx_ready=1, cs_start=0, cs_end=0, active=0, tx_underrun=0. Reset mid-transaction returns to IDLE immediately; no cs_end is issued.

## Timing
- Pin edge to internal action: SYNC_STAGES+1 clk cycles (default 3).
- rx_valid: 3 cycles after the 8th SCLK rise at pin.
- cs_start/cs_end: 3 cycles after the CS edge at pin.
- h_miso changes 3 cycles after the SCLK fall at pin. The first bit is valid 3 cycles after CS fall.
- Constraint: each SCLK phase ≥ SYNC_STAGES+3 clk cycles. The host must hold CS low ≥ SYNC_STAGES+2 cycles before the first SCLK rise.
- The tx byte for index n+1 must be accepted before byte n completes, or 8'hFF is sent.

## Structure
- Package host_spi_pkg: state enum (IDLE, SHIFT), MISO_IDLE=1'b1, TX_FILL=8'hFF.
- Sub-module spi_sync_edge: parameterised synchroniser with reset value plus rise/fall pulse outputs. Instantiated for h_clk and h_cs_n; h_mosi uses sync only (edges unused).

## Test plan
- Reset, CS low, 8 SCLK with MOSI=0x9F, CS high → one rx_valid, rx_data=0x9F, rx_first=1, byte_idx=0; then cs_end; no further rx_valid.
- tx_data 0xA5 then 0x3C preloaded via handshake; 2-byte transaction → host samples 0xA5, 0x3C on MISO; tx_underrun never pulses.
- Transaction with empty tx buffer → MISO reads 0xFF, tx_underrun pulses once at cs_start.
- CS rises after 5 bits → no rx_valid, cs_end pulse, h_miso=1, tx_ready=1.
- rst asserted mid-byte with CS held low, then released → no cs_start until CS toggles high then low; all outputs at reset values.
- IDX_W=2, 6-byte transaction → byte_idx 0,1,2,3,3,3.
